// File: rtl/mem_bus_debug_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_debug_bridge
// Description : UART-byte-driven initiator on the mem_valid/mem_ready bus.
//               It issues one 32-bit read or write per command and returns
//               the result as bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_debug_bridge #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_addr = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_bus  = 3'd3;
    localparam logic [2:0] c_st_resp = 3'd4;

    localparam logic [7:0] c_op_read  = 8'h01;
    localparam logic [7:0] c_op_write = 8'h02;
    localparam logic [7:0] c_rsp_err  = 8'hEE;
    localparam logic [7:0] c_rsp_ok   = 8'hAA;

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

    logic [2:0]      r_state;
    logic            r_is_write;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_mem_valid;
    logic [TO_W-1:0] r_to_cnt;
    logic [31:0]     r_resp;
    logic [2:0]      r_resp_left;
    logic            r_tx_valid;
    logic            r_overrun;
    logic            w_last_byte;

    assign w_last_byte = (r_byte_cnt == 2'd3);

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_resp[31:24];
    assign busy      = (r_state != c_st_idle);
    assign overrun   = r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_is_write  <= 1'b0;
            r_byte_cnt  <= 2'd0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'h0;
            r_mem_valid <= 1'b0;
            r_to_cnt    <= '0;
            r_resp      <= 32'h0;
            r_resp_left <= 3'd0;
            r_tx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (rx_valid && (r_state == c_st_bus || r_state == c_st_resp)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (rx_valid) begin
                        if (rx_data == c_op_read || rx_data == c_op_write) begin
                            r_is_write <= (rx_data == c_op_write);
                            r_byte_cnt <= 2'd0;
                            r_state    <= c_st_addr;
                        end else begin
                            r_resp      <= {c_rsp_err, 24'h0};
                            r_resp_left <= 3'd1;
                            r_tx_valid  <= 1'b1;
                            r_state     <= c_st_resp;
                        end
                    end
                end

                c_st_addr: begin
                    if (rx_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            // Word alignment is applied as the final address byte lands.
                            r_addr <= {r_addr[23:0], rx_data[7:2], 2'b00};
                            if (r_is_write) begin
                                r_state <= c_st_data;
                            end else begin
                                r_wstrb     <= 4'h0;
                                r_mem_valid <= 1'b1;
                                r_to_cnt    <= '0;
                                r_state     <= c_st_bus;
                            end
                        end else begin
                            r_addr <= {r_addr[23:0], rx_data};
                        end
                    end
                end

                c_st_data: begin
                    if (rx_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_wdata    <= {r_wdata[23:0], rx_data};
                        if (w_last_byte) begin
                            r_wstrb     <= 4'hF;
                            r_mem_valid <= 1'b1;
                            r_to_cnt    <= '0;
                            r_state     <= c_st_bus;
                        end
                    end
                end

                c_st_bus: begin
                    // A completion wins over a timeout landing in the same cycle.
                    if (mem_ready && r_mem_valid) begin
                        r_mem_valid <= 1'b0;
                        r_wstrb     <= 4'h0;
                        r_tx_valid  <= 1'b1;
                        r_state     <= c_st_resp;
                        if (r_is_write) begin
                            r_resp      <= {c_rsp_ok, 24'h0};
                            r_resp_left <= 3'd1;
                        end else begin
                            r_resp      <= mem_rdata;
                            r_resp_left <= 3'd4;
                        end
                    end else if (r_to_cnt == c_to_last) begin
                        r_mem_valid <= 1'b0;
                        r_wstrb     <= 4'h0;
                        r_resp      <= {c_rsp_err, 24'h0};
                        r_resp_left <= 3'd1;
                        r_tx_valid  <= 1'b1;
                        r_state     <= c_st_resp;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                c_st_resp: begin
                    if (r_tx_valid && tx_ready) begin
                        if (r_resp_left == 3'd1) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= c_st_idle;
                        end else begin
                            r_resp      <= {r_resp[23:0], 8'h0};
                            r_resp_left <= r_resp_left - 3'd1;
                        end
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_debug_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_debug_bridge
// Description : Self-checking bench for mem_bus_debug_bridge: directed vector
//               table, reset/overrun sequences and randomized commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_debug_bridge;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        busy;
    logic        overrun;

    mem_bus_debug_bridge #(.TIMEOUT(TO), .TO_W(4)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] cmd;
        int          len;
        int          delay;
        logic [31:0] rdata;
        int          mode;
        int          exp_txn;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        chk_wdata;
        logic [31:0] exp_resp;
        int          exp_n;
        int          exp_run;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Environment state: responder, tx sink and protocol monitors.
    int          ack_delay   = -1;
    logic [31:0] resp_rdata  = 32'h0;
    int          ready_mode  = 0;
    bit          spur_en     = 1'b0;
    int          cyc         = 0;
    int          n_txn       = 0;
    int          valid_run   = 0;
    int          last_run    = 0;
    int          viol        = 0;
    logic [31:0] got_addr, got_wdata;
    logic [3:0]  got_wstrb;
    logic [7:0]  q_tx[$];
    logic        p_txv = 1'b0, p_txr = 1'b0, p_mv = 1'b0, p_mr = 1'b0;
    logic [7:0]  p_txd = 8'h0;
    logic [31:0] p_ma = 32'h0, p_mwd = 32'h0;
    logic [3:0]  p_mws = 4'h0;

    always @(negedge clk) begin
        cyc++;
        if (p_txv && !p_txr && (tx_valid !== 1'b1 || tx_data !== p_txd)) viol++;
        if (p_mv && !p_mr && mem_valid &&
            (mem_addr !== p_ma || mem_wdata !== p_mwd || mem_wstrb !== p_mws)) viol++;
        if (p_mv && p_mr && mem_valid) viol++;
        if (mem_valid) valid_run++;
        else if (p_mv) begin
            last_run  = valid_run;
            valid_run = 0;
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (mem_valid) begin
            if (ack_delay >= 0 && valid_run - 1 == ack_delay) begin
                mem_ready = 1'b1;
                mem_rdata = resp_rdata;
                n_txn++;
                got_addr  = mem_addr;
                got_wdata = mem_wdata;
                got_wstrb = mem_wstrb;
            end
        end else if (spur_en) begin
            mem_ready = ($urandom_range(0, 1) == 1);
        end
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (tx_valid && tx_ready) q_tx.push_back(tx_data);
        p_txv = tx_valid;  p_txr = tx_ready; p_txd = tx_data;
        p_mv  = mem_valid; p_mr  = mem_ready;
        p_ma  = mem_addr;  p_mwd = mem_wdata; p_mws = mem_wstrb;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic vec_t mkv(input logic [71:0] cmd, input int len, input int dly,
                                 input logic [31:0] rd, input int mode, input int txn,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] ws, input logic chkw,
                                 input logic [31:0] resp, input int n, input int run);
        vec_t v;
        v.cmd = cmd; v.len = len; v.delay = dly; v.rdata = rd; v.mode = mode;
        v.exp_txn = txn; v.exp_addr = addr; v.exp_wdata = wd; v.exp_wstrb = ws;
        v.chk_wdata = chkw; v.exp_resp = resp; v.exp_n = n; v.exp_run = run;
        return v;
    endfunction

    // Reference model: expected outcome of one command from the command rules.
    function automatic vec_t model(input int op, input logic [31:0] a, input logic [31:0] d,
                                   input int dly, input logic [31:0] rd, input int mode,
                                   input logic [7:0] badb);
        vec_t v;
        bit   timed_out;
        v = mkv(72'h0, 1, dly, rd, mode, 0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hEE000000, 1, 0);
        if (op == 0) begin
            v.cmd = {badb, 64'h0};
            return v;
        end
        timed_out   = (dly >= TO);
        v.cmd       = (op == 1) ? {8'h01, a, 32'h0} : {8'h02, a, d};
        v.len       = (op == 1) ? 5 : 9;
        v.exp_addr  = {a[31:2], 2'b00};
        v.exp_wdata = d;
        v.exp_wstrb = (op == 2) ? 4'hF : 4'h0;
        v.chk_wdata = (op == 2);
        if (timed_out) begin
            v.exp_run = TO;
        end else begin
            v.exp_txn  = 1;
            v.exp_run  = dly + 1;
            v.exp_resp = (op == 1) ? rd : 32'hAA000000;
            v.exp_n    = (op == 1) ? 4 : 1;
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag, input bit inject);
        int k;
        ack_delay  = v.delay;
        resp_rdata = v.rdata;
        ready_mode = v.mode;
        q_tx.delete();
        n_txn = 0; last_run = 0; viol = 0;
        for (int i = 0; i < v.len; i++) send_byte(v.cmd[71-8*i -: 8]);
        check({tag, " valid_after_last"}, {31'h0, mem_valid}, (v.exp_run > 0) ? 32'd1 : 32'd0);
        if (inject) send_byte(8'h77);
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, " idle"}, {31'h0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check({tag, " txn"}, n_txn, v.exp_txn);
        if (v.exp_txn == 1) begin
            check({tag, " addr"}, got_addr, v.exp_addr);
            check({tag, " wstrb"}, {28'h0, got_wstrb}, {28'h0, v.exp_wstrb});
            if (v.chk_wdata) check({tag, " wdata"}, got_wdata, v.exp_wdata);
        end
        check({tag, " nbytes"}, q_tx.size(), v.exp_n);
        for (int i = 0; i < v.exp_n && i < q_tx.size(); i++)
            check($sformatf("%s byte%0d", tag, i), {24'h0, q_tx[i]}, {24'h0, v.exp_resp[31-8*i -: 8]});
        check({tag, " valid_cycles"}, last_run, v.exp_run);
        check({tag, " protocol"}, viol, 0);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t rv;
        int   k;
        rst = 1'b1; rx_data = 8'h0; rx_valid = 1'b0;
        tx_ready = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0;

        vecs[0] = mkv(72'h02_02000000_DEADBEEF, 9, 1, 32'h0, 0, 1, 32'h02000000, 32'hDEADBEEF,
                      4'hF, 1'b1, 32'hAA000000, 1, 2);
        vecs[1] = mkv(72'h01_01000007_00000000, 5, 0, 32'h12345678, 0, 1, 32'h01000004, 32'h0,
                      4'h0, 1'b0, 32'h12345678, 4, 1);
        vecs[2] = mkv(72'h01_01000007_00000000, 5, 3, 32'h12345678, 1, 1, 32'h01000004, 32'h0,
                      4'h0, 1'b0, 32'h12345678, 4, 4);
        vecs[3] = mkv(72'h55_00000000_00000000, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0,
                      4'h0, 1'b0, 32'hEE000000, 1, 0);
        vecs[4] = mkv(72'h01_00001003_00000000, 5, 2, 32'hCAFEF00D, 2, 1, 32'h00001000, 32'h0,
                      4'h0, 1'b0, 32'hCAFEF00D, 4, 3);
        vecs[5] = mkv(72'h01_ABCDEF01_00000000, 5, -1, 32'h0, 0, 0, 32'h0, 32'h0,
                      4'h0, 1'b0, 32'hEE000000, 1, 16);
        vecs[6] = mkv(72'h02_10000002_A5A55A5A, 9, 15, 32'h0, 1, 1, 32'h10000000, 32'hA5A55A5A,
                      4'hF, 1'b1, 32'hAA000000, 1, 16);
        vecs[7] = mkv(72'h01_00000000_00000000, 5, 16, 32'h0, 0, 0, 32'h0, 32'h0,
                      4'h0, 1'b0, 32'hEE000000, 1, 16);

        repeat (3) @(negedge clk);
        check("rst mem_valid", {31'h0, mem_valid}, 32'd0);
        check("rst tx_valid", {31'h0, tx_valid}, 32'd0);
        check("rst busy", {31'h0, busy}, 32'd0);
        check("rst overrun", {31'h0, overrun}, 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst tx_data", {24'h0, tx_data}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
        check("no overrun yet", {31'h0, overrun}, 32'd0);

        // Byte arriving while the bus transaction is outstanding.
        rv = model(1, 32'h00000022, 32'h0, 5, 32'h0BADF00D, 0, 8'h0);
        run_vec(rv, "ovr", 1'b1);
        check("ovr sticky", {31'h0, overrun}, 32'd1);
        rv = model(2, 32'h00000040, 32'h01020304, 0, 32'h0, 0, 8'h0);
        run_vec(rv, "ovr_next", 1'b0);
        check("ovr still set", {31'h0, overrun}, 32'd1);

        // Reset in the middle of a bus request.
        ack_delay = -1; ready_mode = 0; q_tx.delete(); n_txn = 0;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        repeat (3) @(negedge clk);
        check("mid_rst valid before", {31'h0, mem_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst valid dropped", {31'h0, mem_valid}, 32'd0);
        check("mid_rst busy", {31'h0, busy}, 32'd0);
        check("mid_rst overrun cleared", {31'h0, overrun}, 32'd0);
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_valid || tx_valid) k++;
        end
        check("mid_rst quiet", k, 0);
        check("mid_rst no tx", q_tx.size(), 0);

        // Randomized commands against the reference model, spurious idle acks on.
        spur_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] bb;
            bb = 8'($urandom);
            if (bb == 8'h01 || bb == 8'h02) bb = 8'h00;
            rv = model($urandom_range(0, 2), $urandom, $urandom, $urandom_range(0, TO + 3),
                       $urandom, $urandom_range(0, 2), bb);
            run_vec(rv, $sformatf("rnd%0d", i), 1'b0);
        end
        spur_en = 1'b0;
        check("rnd overrun clear", {31'h0, overrun}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
